load_store_unit: RTL

- Multi-cycle load/store unit directly downstream of the core's EXECUTE state.
- Accepts one LOAD/STORE request per transaction: base register value, immediate, store data and funct3.
- Computes the byte address, checks alignment, and drives a single-strobe word memory bus. Aligned addresses are forced to word granularity on the bus.
- Returns sign/zero-extended load data, or a store completion, as a one-cycle done pulse with an error flag.

---
 rtl/load_store_unit.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit: address generation, alignment check, single-strobe
// word bus transaction with optional wait-state timeout, and load data extension.
module load_store_unit #(
   parameter int unsigned TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   input  logic        req_store,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_base,
   input  logic [31:0] req_imm,
   input  logic [31:0] req_wdata,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [31:0] load_data,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wmask,
   output logic        mem_rstrb,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ready
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

   state_t      state_q, state_d;
   logic [1:0]  alo_q, alo_d;
   logic        store_q, store_d;
   logic [2:0]  funct3_q, funct3_d;
   logic        err_q, err_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [31:0] ld_q, ld_d;
   logic [31:0] maddr_q, maddr_d;
   logic [31:0] mwdata_q, mwdata_d;
   logic [31:0] req_addr;
   logic [3:0]  wmask_c;

   // Rejects illegal funct3 for the access kind as well as misaligned halves/words.
   function automatic logic req_bad(input logic st, input logic [2:0] f3, input logic [1:0] a);
      logic bad;
      case (f3)
         3'b000:  bad = 1'b0;
         3'b001:  bad = a[0];
         3'b010:  bad = (a != 2'b00);
         3'b100:  bad = st;
         3'b101:  bad = st | a[0];
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

   function automatic logic [31:0] replicate(input logic [2:0] f3, input logic [31:0] wd);
      logic [31:0] r;
      case (f3[1:0])
         2'b00:   r = {4{wd[7:0]}};
         2'b01:   r = {2{wd[15:0]}};
         default: r = wd;
      endcase
      return r;
   endfunction

   function automatic logic [31:0] extend(input logic [2:0] f3, input logic [1:0] a,
                                          input logic [31:0] rd);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      b = rd[8*a +: 8];
      h = rd[16*a[1] +: 16];
      case (f3)
         3'b000:  r = {{24{b[7]}}, b};
         3'b001:  r = {{16{h[15]}}, h};
         3'b100:  r = {24'd0, b};
         3'b101:  r = {16'd0, h};
         default: r = rd;
      endcase
      return r;
   endfunction

   assign req_addr = req_base + req_imm;

   always_comb begin
      case (funct3_q)
         3'b000:  wmask_c = 4'b0001 << alo_q;
         3'b001:  wmask_c = alo_q[1] ? 4'b1100 : 4'b0011;
         default: wmask_c = 4'b1111;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      alo_d    = alo_q;
      store_d  = store_q;
      funct3_d = funct3_q;
      err_d    = err_q;
      cnt_d    = cnt_q;
      ld_d     = ld_q;
      maddr_d  = maddr_q;
      mwdata_d = mwdata_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               alo_d    = req_addr[1:0];
               store_d  = req_store;
               funct3_d = req_funct3;
               maddr_d  = {req_addr[31:2], 2'b00};
               mwdata_d = replicate(req_funct3, req_wdata);
               err_d    = req_bad(req_store, req_funct3, req_addr[1:0]);
               state_d  = err_d ? S_RESP : S_REQ;
            end
         end
         S_REQ: begin
            if (mem_ready) begin
               if (!store_q) ld_d = extend(funct3_q, alo_q, mem_rdata);
               state_d = S_RESP;
            end else begin
               cnt_d   = '0;
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (mem_ready) begin
               if (!store_q) ld_d = extend(funct3_q, alo_q, mem_rdata);
               state_d = S_RESP;
            end else if (TIMEOUT != 0 && cnt_q == TO_LAST) begin
               err_d   = 1'b1;
               state_d = S_RESP;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         alo_q    <= '0;
         store_q  <= 1'b0;
         funct3_q <= '0;
         err_q    <= 1'b0;
         cnt_q    <= '0;
         ld_q     <= '0;
         maddr_q  <= '0;
         mwdata_q <= '0;
      end else begin
         state_q  <= state_d;
         alo_q    <= alo_d;
         store_q  <= store_d;
         funct3_q <= funct3_d;
         err_q    <= err_d;
         cnt_q    <= cnt_d;
         ld_q     <= ld_d;
         maddr_q  <= maddr_d;
         mwdata_q <= mwdata_d;
      end
   end

   assign busy      = (state_q != S_IDLE);
   assign done      = (state_q == S_RESP);
   assign err       = done & err_q;
   assign load_data = ld_q;
   assign mem_addr  = maddr_q;
   assign mem_wdata = mwdata_q;
   assign mem_rstrb = (state_q == S_REQ) && !store_q;
   assign mem_wmask = ((state_q == S_REQ) && store_q) ? wmask_c : '0;

endmodule
